// File: rtl/key_debounce_if.sv
// Key front-end signal bundle: raw pin in, debounced level/events/count out.
// The slave modport is the debouncer; the master modport is its environment.
interface key_debounce_if;
    logic       key_in;
    logic       key_out;
    logic       key_press;
    logic       key_release;
    logic [7:0] press_cnt;

    modport slave (
        input  key_in,
        output key_out,
        output key_press,
        output key_release,
        output press_cnt
    );

    modport master (
        output key_in,
        input  key_out,
        input  key_press,
        input  key_release,
        input  press_cnt
    );
endinterface

// File: rtl/key_debounce.sv
// Active-low push-button synchroniser + debouncer with press/release pulses and a wrapping press count.
// Latency: DEBOUNCE_CYC+2 cycles from a clean pin edge to key_out/pulse; no backpressure (pulses are fire-and-forget).
// Optional auto-repeat while held is enabled by defining KEY_REPEAT_EN.
module key_debounce #(
    parameter int DEBOUNCE_CYC = 20,
    parameter int CNT_W        = 16,
    parameter int REPEAT_DLY   = 500,
    parameter int REPEAT_PER   = 100
) (
    input  logic           clk,
    input  logic           rst_n,
    key_debounce_if.slave  kif
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] THR     = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    if (DEBOUNCE_CYC < 2 || REPEAT_DLY < 1 || REPEAT_PER < 1) begin : g_bad_cfg
        $error("key_debounce: illegal timing parameters");
    end

    logic             sync1;
    logic             ks;
    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             key_out_q, key_out_nxt;
    logic             press_q, press_nxt;
    logic             release_q, release_nxt;
    logic [7:0]       press_cnt_q;

`ifdef KEY_REPEAT_EN
    localparam logic [CNT_W-1:0] DLY_THR = CNT_W'(REPEAT_DLY - 1);
    localparam logic [CNT_W-1:0] PER_THR = CNT_W'(REPEAT_PER - 1);
    logic [CNT_W-1:0] hold_cnt, hold_cnt_nxt;
    logic             rep_started, rep_started_nxt;
`endif

    // Two-flop synchroniser; idles high so reset looks like a released key.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            ks    <= 1'b1;
        end else begin
            sync1 <= kif.key_in;
            ks    <= sync1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            key_out_q   <= 1'b1;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            press_cnt_q <= 8'd0;
`ifdef KEY_REPEAT_EN
            hold_cnt    <= '0;
            rep_started <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            key_out_q <= key_out_nxt;
            press_q   <= press_nxt;
            release_q <= release_nxt;
            if (press_nxt) begin
                press_cnt_q <= press_cnt_q + 8'd1;
            end
`ifdef KEY_REPEAT_EN
            hold_cnt    <= hold_cnt_nxt;
            rep_started <= rep_started_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt       = state;
        cnt_nxt         = cnt;
        key_out_nxt     = key_out_q;
        press_nxt       = 1'b0;
        release_nxt     = 1'b0;
`ifdef KEY_REPEAT_EN
        hold_cnt_nxt    = hold_cnt;
        rep_started_nxt = rep_started;
`endif
        case (state)
            IDLE: begin
                if (!ks) begin
                    state_nxt = PRESS_WAIT;
                    cnt_nxt   = CNT_ONE;
                end
            end
            PRESS_WAIT: begin
                if (ks) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == THR) begin
                    state_nxt   = PRESSED;
                    key_out_nxt = 1'b0;
                    press_nxt   = 1'b1;
                    cnt_nxt     = '0;
`ifdef KEY_REPEAT_EN
                    hold_cnt_nxt    = '0;
                    rep_started_nxt = 1'b0;
`endif
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            PRESSED: begin
                if (ks) begin
                    state_nxt = RELEASE_WAIT;
                    cnt_nxt   = CNT_ONE;
`ifdef KEY_REPEAT_EN
                    hold_cnt_nxt    = '0;
                    rep_started_nxt = 1'b0;
                end else begin
                    // First repeat waits the long delay, later ones the short period.
                    if ((!rep_started && hold_cnt == DLY_THR) ||
                        ( rep_started && hold_cnt == PER_THR)) begin
                        press_nxt       = 1'b1;
                        hold_cnt_nxt    = '0;
                        rep_started_nxt = 1'b1;
                    end else begin
                        hold_cnt_nxt = hold_cnt + CNT_ONE;
                    end
`endif
                end
            end
            RELEASE_WAIT: begin
                if (!ks) begin
                    state_nxt = PRESSED;
                    cnt_nxt   = '0;
                end else if (cnt == THR) begin
                    state_nxt   = IDLE;
                    key_out_nxt = 1'b1;
                    release_nxt = 1'b1;
                    cnt_nxt     = '0;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign kif.key_out     = key_out_q;
    assign kif.key_press   = press_q;
    assign kif.key_release = release_q;
    assign kif.press_cnt   = press_cnt_q;

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce (DEBOUNCE_CYC=4, REPEAT_DLY=10, REPEAT_PER=3).
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_key_debounce;

    logic clk;
    logic rst_n;
    int   n_pass = 0;
    int   n_total = 0;
    int   press_seen = 0;
    int   rel_seen = 0;
    int   both_seen = 0;

`ifdef KEY_REPEAT_EN
    localparam int          CLEAN_CNT   = 4;
    localparam int          REP_CNT     = 8;
    localparam logic [63:0] REP_MASK    = (64'd1 << 6) | (64'd1 << 16) | (64'd1 << 19) | (64'd1 << 22) |
                                          (64'd1 << 25) | (64'd1 << 28) | (64'd1 << 31) | (64'd1 << 34);
`else
    localparam int          CLEAN_CNT   = 1;
    localparam int          REP_CNT     = 1;
    localparam logic [63:0] REP_MASK    = (64'd1 << 6);
`endif
    localparam logic [63:0] REL_MASK    = (64'd1 << 39);

    key_debounce_if kif ();

    key_debounce #(
        .DEBOUNCE_CYC (4),
        .CNT_W        (16),
        .REPEAT_DLY   (10),
        .REPEAT_PER   (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .kif   (kif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (kif.key_press)   press_seen++;
            if (kif.key_release) rel_seen++;
            if (kif.key_press && kif.key_release) both_seen++;
        end
    endtask

    task automatic do_reset();
        kif.key_in = 1'b1;
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(2);
        press_seen = 0;
        rel_seen   = 0;
    endtask

    task automatic test_reset();
        kif.key_in = 1'b1;
        rst_n = 1'b0;
        tick(2);
        n_total++; if (kif.key_out !== 1'b1) $display("FAIL reset_key_out: got %b want 1", kif.key_out); else n_pass++;
        n_total++; if (kif.press_cnt !== 8'd0) $display("FAIL reset_press_cnt: got %0d want 0", kif.press_cnt); else n_pass++;
        n_total++; if (kif.key_press !== 1'b0 || kif.key_release !== 1'b0)
            $display("FAIL reset_pulses: got %b%b want 00", kif.key_press, kif.key_release); else n_pass++;
        rst_n = 1'b1;
        tick(2);
        kif.key_in = 1'b0;
        tick(7);
        n_total++; if (kif.key_out !== 1'b0 || kif.press_cnt !== 8'd1)
            $display("FAIL pre_reset_press: got out=%b cnt=%0d want out=0 cnt=1", kif.key_out, kif.press_cnt); else n_pass++;
        // Assert reset between edges with the key still held down.
        #3 rst_n = 1'b0;
        #1;
        n_total++; if (kif.key_out !== 1'b1 || kif.press_cnt !== 8'd0 || kif.key_press !== 1'b0)
            $display("FAIL async_reset: got out=%b cnt=%0d press=%b want 1/0/0", kif.key_out, kif.press_cnt, kif.key_press); else n_pass++;
        @(posedge clk);
        #1 rst_n = 1'b1;
        press_seen = 0;
        tick(5);
        n_total++; if (kif.key_press !== 1'b0 || kif.key_out !== 1'b1 || press_seen != 0)
            $display("FAIL post_reset_early: got press=%b out=%b seen=%0d want 0/1/0", kif.key_press, kif.key_out, press_seen); else n_pass++;
        tick(1);
        n_total++; if (kif.key_press !== 1'b1 || kif.key_out !== 1'b0 || kif.press_cnt !== 8'd1)
            $display("FAIL post_reset_press: got press=%b out=%b cnt=%0d want 1/0/1", kif.key_press, kif.key_out, kif.press_cnt); else n_pass++;
        kif.key_in = 1'b1;
        tick(8);
    endtask

    task automatic test_clean_press();
        do_reset();
        kif.key_in = 1'b0;
        tick(5);
        n_total++; if (kif.key_out !== 1'b1 || kif.key_press !== 1'b0)
            $display("FAIL clean_before: got out=%b press=%b want 1/0", kif.key_out, kif.key_press); else n_pass++;
        tick(1);
        n_total++; if (kif.key_out !== 1'b0 || kif.key_press !== 1'b1)
            $display("FAIL clean_accept: got out=%b press=%b want 0/1", kif.key_out, kif.key_press); else n_pass++;
        tick(1);
        n_total++; if (kif.key_press !== 1'b0) $display("FAIL clean_pulse_width: got %b want 0", kif.key_press); else n_pass++;
        tick(13);
        kif.key_in = 1'b1;
        tick(5);
        n_total++; if (kif.key_out !== 1'b0 || rel_seen != 0)
            $display("FAIL clean_rel_early: got out=%b rel=%0d want 0/0", kif.key_out, rel_seen); else n_pass++;
        tick(1);
        n_total++; if (kif.key_out !== 1'b1 || kif.key_release !== 1'b1)
            $display("FAIL clean_release: got out=%b rel=%b want 1/1", kif.key_out, kif.key_release); else n_pass++;
        tick(1);
        n_total++; if (kif.key_release !== 1'b0) $display("FAIL clean_rel_width: got %b want 0", kif.key_release); else n_pass++;
        n_total++; if (kif.press_cnt !== 8'(CLEAN_CNT))
            $display("FAIL clean_press_cnt: got %0d want %0d", kif.press_cnt, CLEAN_CNT); else n_pass++;
    endtask

    task automatic test_bounce();
        int bad_out;
        do_reset();
        bad_out = 0;
        for (int p = 0; p < 5; p++) begin
            kif.key_in = 1'b0; tick(2); if (kif.key_out !== 1'b1) bad_out++;
            kif.key_in = 1'b1; tick(2); if (kif.key_out !== 1'b1) bad_out++;
        end
        tick(6);
        n_total++; if (bad_out != 0 || kif.key_out !== 1'b1)
            $display("FAIL bounce_idle_level: got bad=%0d out=%b want 0/1", bad_out, kif.key_out); else n_pass++;
        n_total++; if (press_seen != 0 || kif.press_cnt !== 8'd0)
            $display("FAIL bounce_idle_press: got seen=%0d cnt=%0d want 0/0", press_seen, kif.press_cnt); else n_pass++;
        kif.key_in = 1'b0;
        tick(7);
        bad_out = 0;
        for (int p = 0; p < 5; p++) begin
            kif.key_in = 1'b1; tick(2); if (kif.key_out !== 1'b0) bad_out++;
            kif.key_in = 1'b0; tick(2); if (kif.key_out !== 1'b0) bad_out++;
        end
        tick(4);
        n_total++; if (bad_out != 0 || kif.key_out !== 1'b0 || rel_seen != 0)
            $display("FAIL bounce_pressed: got bad=%0d out=%b rel=%0d want 0/0/0", bad_out, kif.key_out, rel_seen); else n_pass++;
        kif.key_in = 1'b1;
        tick(8);
        n_total++; if (kif.key_out !== 1'b1 || rel_seen != 1)
            $display("FAIL bounce_final_release: got out=%b rel=%0d want 1/1", kif.key_out, rel_seen); else n_pass++;
    endtask

    task automatic test_near_threshold();
        do_reset();
        kif.key_in = 1'b0;
        tick(3);
        kif.key_in = 1'b1;
        tick(10);
        n_total++; if (press_seen != 0 || kif.key_out !== 1'b1)
            $display("FAIL glitch3: got seen=%0d out=%b want 0/1", press_seen, kif.key_out); else n_pass++;
        kif.key_in = 1'b0;
        tick(4);
        kif.key_in = 1'b1;
        tick(2);
        n_total++; if (kif.key_press !== 1'b1 || kif.key_out !== 1'b0)
            $display("FAIL glitch4_press: got press=%b out=%b want 1/0", kif.key_press, kif.key_out); else n_pass++;
        tick(3);
        n_total++; if (kif.key_release !== 1'b0) $display("FAIL glitch4_rel_early: got %b want 0", kif.key_release); else n_pass++;
        tick(1);
        n_total++; if (kif.key_release !== 1'b1 || kif.key_out !== 1'b1 || press_seen != 1)
            $display("FAIL glitch4_release: got rel=%b out=%b seen=%0d want 1/1/1", kif.key_release, kif.key_out, press_seen); else n_pass++;
        tick(4);
    endtask

    task automatic test_repeat();
        logic [63:0] pmask;
        logic [63:0] rmask;
        do_reset();
        pmask = '0;
        rmask = '0;
        kif.key_in = 1'b0;
        for (int i = 1; i <= 45; i++) begin
            tick(1);
            if (kif.key_press)   pmask[i] = 1'b1;
            if (kif.key_release) rmask[i] = 1'b1;
            if (i == 33) kif.key_in = 1'b1;
        end
        n_total++; if (pmask !== REP_MASK) $display("FAIL repeat_press_times: got %h want %h", pmask, REP_MASK); else n_pass++;
        n_total++; if (rmask !== REL_MASK) $display("FAIL repeat_release_time: got %h want %h", rmask, REL_MASK); else n_pass++;
        n_total++; if (kif.press_cnt !== 8'(REP_CNT))
            $display("FAIL repeat_press_cnt: got %0d want %0d", kif.press_cnt, REP_CNT); else n_pass++;
    endtask

    task automatic test_wrap();
        do_reset();
        for (int n = 0; n < 256; n++) begin
            kif.key_in = 1'b0;
            tick(7);
            kif.key_in = 1'b1;
            tick(7);
            if (n == 254) begin
                n_total++; if (kif.press_cnt !== 8'd255)
                    $display("FAIL wrap_255: got %0d want 255", kif.press_cnt); else n_pass++;
            end
        end
        n_total++; if (kif.press_cnt !== 8'd0) $display("FAIL wrap_cnt: got %0d want 0", kif.press_cnt); else n_pass++;
        n_total++; if (press_seen != 256 || rel_seen != 256)
            $display("FAIL wrap_pulses: got press=%0d rel=%0d want 256/256", press_seen, rel_seen); else n_pass++;
    endtask

    initial begin
        rst_n = 1'b0;
        kif.key_in = 1'b1;
        test_reset();
        test_clean_press();
        test_bounce();
        test_near_threshold();
        test_repeat();
        test_wrap();
        n_total++; if (both_seen != 0) $display("FAIL pulse_exclusive: got %0d overlaps want 0", both_seen); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
